// File: rtl/muldiv_ctrl_pkg.sv
// mips_pkg: opcode/funct constants and the HI/LO sequencer state type.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;

    function automatic logic is_md(input logic [5:0] fn);
        return fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    function automatic logic is_hilo(input logic [5:0] fn);
        return is_md(fn) || fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO};
    endfunction
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage to HI/LO unit handshake and result bus.
interface muldiv_ctrl_if;
    logic        Start;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic        Stall;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (output Start, Ins, Rdata1, Rdata2,
                    input  Stall, Busy, Done, Result, Hi, Lo);
    modport slave  (input  Start, Ins, Rdata1, Rdata2,
                    output Stall, Busy, Done, Result, Hi, Lo);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on a 64-bit accumulator.
module muldiv_step (
    input  logic [63:0] acc_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        is_div_i,
    output logic [63:0] acc_o,
    output logic        qbit_o
);
    logic [32:0] sum, diff;
    // Divide: the shifted partial remainder is 33 bits, so its top bit joins the compare.
    assign sum    = {1'b0, acc_i[63:32]} + {1'b0, a_i};
    assign diff   = acc_i[63:31] - {1'b0, b_i};
    assign qbit_o = is_div_i & ~diff[32];
    assign acc_o  = is_div_i ? {qbit_o ? diff[31:0] : acc_i[62:31], acc_i[30:0], qbit_o}
                             : {acc_i[0] ? sum : {1'b0, acc_i[63:32]}, acc_i[31:1]};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and 32-step iterative mult/div sequencer for the EX stage.
import mips_pkg::*;

module muldiv_ctrl (
    input logic          CLK,
    input logic          RST,
    muldiv_ctrl_if.slave bus
);
    muldiv_state_t state_q;
    logic [4:0]    cnt_q;
    logic [63:0]   acc_q, acc_d, prod_d;
    logic [31:0]   a_q, b_q, hi_q, lo_q, fix_hi_d, fix_lo_d, mag_a, mag_b;
    logic          is_div_q, neg_q, rneg_q, busy_q, done_q;
    logic [5:0]    funct;
    logic          cls, accept, is_signed, is_div, sgn_a, sgn_b, div0, qbit;

    assign funct     = bus.Ins[5:0];
    assign cls       = bus.Start && bus.Ins[31:26] == OP_RTYPE && is_hilo(funct);
    assign accept    = cls && state_q == IDLE;
    assign is_signed = funct == FN_MULT || funct == FN_DIV;
    assign is_div    = funct == FN_DIV || funct == FN_DIVU;
    assign sgn_a     = is_signed & bus.Rdata1[31];
    assign sgn_b     = is_signed & bus.Rdata2[31];
    assign mag_a     = sgn_a ? -bus.Rdata1 : bus.Rdata1;
    assign mag_b     = sgn_b ? -bus.Rdata2 : bus.Rdata2;
    assign div0      = is_div && bus.Rdata2 == 32'h0;

    muldiv_step u_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_d),
        .qbit_o   (qbit)
    );

    // Divide leaves quotient in acc[31:0] and remainder in acc[63:32].
    always_comb begin
        prod_d   = neg_q ? -acc_q : acc_q;
        fix_hi_d = is_div_q ? (rneg_q ? -acc_q[63:32] : acc_q[63:32]) : prod_d[63:32];
        fix_lo_d = is_div_q ? (neg_q ? -acc_q[31:0] : acc_q[31:0]) : prod_d[31:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    if (funct == FN_MTHI) hi_q <= bus.Rdata1;
                    if (funct == FN_MTLO) lo_q <= bus.Rdata1;
                    if (is_md(funct)) begin
                        // Divide by zero skips CALC and reports q=all-ones, r=dividend unmodified.
                        is_div_q <= is_div;
                        neg_q    <= ~div0 & (sgn_a ^ sgn_b);
                        rneg_q   <= ~div0 & sgn_a;
                        a_q      <= mag_a;
                        b_q      <= mag_b;
                        cnt_q    <= 5'd0;
                        acc_q    <= div0 ? {bus.Rdata1, 32'hFFFF_FFFF} : {32'h0, is_div ? mag_a : mag_b};
                        state_q  <= div0 ? FIX : CALC;
                        busy_q   <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Stall  = cls && state_q != IDLE;
    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Hi     = hi_q;
    assign bus.Lo     = lo_q;
    assign bus.Result = !cls ? 32'h0 : funct == FN_MFHI ? hi_q : funct == FN_MFLO ? lo_q : 32'h0;
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the EX stage. Accepts MULT, MULTU, DIV, DIVU, MFHI, MTHI, MFLO and MTLO from EX and runs multiply/divide as a 32-step iterative operation. While the unit is busy it stalls any further HI/LO-class instruction. Non-HI/LO instructions pass through EX untouched.

## Interface
- No parameters. Width is fixed at 32 bits, with a 64-bit product and a 32-step iteration.
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-low reset
- Start  in  1  EX holds a valid instruction this cycle
- Ins  in  32  instruction; Ins[31:26] is the opcode, Ins[5:0] is funct
- Rdata1  in  32  rs value (dividend / multiplicand / MTHI-MTLO source)
- Rdata2  in  32  rt value (divisor / multiplier)
- Stall  out  1  combinational; EX must hold Ins/Rdata and re-present them next cycle
- Busy  out  1  registered; a mult/div is in flight
- Done  out  1  registered; one-cycle pulse when HI/LO receive a mult/div result
- Result  out  32  combinational; HI for MFHI, LO for MFLO, 0 otherwise
- Hi, Lo  out  32 each  registered architectural HI/LO (debug/trace)

## Operation
- HI/LO class: Start=1, Ins[31:26]=6'h00, funct in {10,11,12,13,18,19,1A,1B}. Every other instruction leaves the block's state and outputs unchanged.
- Stall = Start & HI/LO class & (state != IDLE).
- A class instruction is accepted when Start=1, it is HI/LO class and Stall=0.
- States are IDLE, CALC, FIX.
- IDLE:
  - MTHI: Hi<=Rdata1. MTLO: Lo<=Rdata1. Both write at the accepting edge.
  - MFHI/MFLO: no state change; Result is valid in the same cycle.
  - MULT/MULTU/DIV/DIVU with a nonzero divisor or any multiply: latch the operands and go to CALC with count=0. For signed ops, latch magnitudes plus the result sign flags.
  - DIV/DIVU with Rdata2=0: go to FIX directly with q=32'hFFFFFFFF and r=Rdata1. No CALC.
- CALC: one muldiv_step per cycle; count increments.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring subtract, one quotient bit per step.
  - At count=31 the next state is FIX.
- FIX: apply the sign correction, then write Hi/Lo.
  - Multiply: {Hi,Lo} = product, negated in two's complement if the signs differ (MULT only).
  - Divide: Lo = quotient, negated if the signs differ. Hi = remainder, taking the dividend's sign (DIV only).
  - After FIX: Done=1 for one cycle and state returns to IDLE.
- Arithmetic wraps modulo 2^32/2^64. DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Result = Hi when funct=10, Lo when funct=12, else 0. It is driven even while stalled, but EX ignores it then.

## Timing
- Reset (RST=0, asynchronous): state=IDLE, count=0, Hi=0, Lo=0, Busy=0, Done=0; operand and accumulator registers are 0.
- Reset mid-operation aborts the operation. HI/LO read 0 immediately and Done is not pulsed.
- Mult/div latency:
  - Accept edge E0.
  - CALC covers edges E1..E32.
  - FIX writes Hi/Lo at E33.
  - Busy=1 from after E0 until after E33.
  - Done=1 between E33 and E34.
- Divide-by-zero: accept E0, FIX at E1, Done between E1 and E2.
- An instruction stalled during FIX is accepted at the first edge after Busy falls. An MFHI presented in that cycle returns the new Hi.
- MTHI/MTLO/MFHI/MFLO while idle take one cycle and never stall.
- A mult/div is accepted back-to-back in the cycle after Busy falls.
- Done and a new accept may coincide.

## Structure
- mips_pkg holds:
  - funct constants: FN_MFHI=6'h10, FN_MTHI=6'h11, FN_MFLO=6'h12, FN_MTLO=6'h13, FN_MULT=6'h18, FN_MULTU=6'h19, FN_DIV=6'h1A, FN_DIVU=6'h1B
  - OP_RTYPE=6'h00
  - the muldiv_state_t enum {IDLE, CALC, FIX}
- Sub-module muldiv_step: combinational. It takes the accumulator, operands and an is_div flag, and returns the next accumulator and the quotient bit.
- muldiv_ctrl holds the FSM, counter, sign flags and the HI/LO registers.

## Test plan
- Reset, then MTHI 32'h1234 and MTLO 32'h5678, then MFHI and MFLO: Result reads 32'h1234 then 32'h5678, with no Stall.
- MULT 0xFFFFFFFF x 2 (signed): Busy for 33 cycles, then Hi=0xFFFFFFFF, Lo=0xFFFFFFFE with Done one cycle. MULTU on the same operands: Hi=1, Lo=0xFFFFFFFE.
- DIV -7 / 2: Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 7 / 2: Lo=3, Hi=1. DIV 0x80000000 / -1: Lo=0x80000000, Hi=0.
- DIVU 5 / 0: Done at E1, Lo=0xFFFFFFFF, Hi=5, Busy for one cycle.
- MFLO issued 3 cycles after MULT 3x4: Stall=1 until Busy falls. The MFLO is then accepted with Result=12. An ADD presented while busy gets Stall=0.
- Drive RST low at CALC count=10: Busy, Done, Hi and Lo go to 0 immediately. After release, MTLO 1 works normally.
